// File: rtl/cla_nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_nibble_serial_adder_pkg
//  Description : State encoding and nibble width shared by the serial
//                carry-lookahead adder and its slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_nibble_serial_adder_pkg;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_RUN   = 2'd1;
  localparam logic [1:0] C_DONE  = 2'd2;
  localparam int         C_NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = C_IDLE,
    S_RUN  = C_RUN,
    S_DONE = C_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cla_nibble_serial_adder_cla.sv
`default_nettype none
// ============================================================================
//  Module      : carry_lookahead_adder_4_bit
//  Description : 4-bit carry-lookahead slice; all carries are computed
//                directly from generate/propagate terms and carry-in.
//  Revision    : 1.0 - initial release
// ============================================================================
module carry_lookahead_adder_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Flattened lookahead equations; no carry ripples through the slice.
  always_comb begin
    w_c[0] = cin;
    w_c[1] = w_g[0] | (w_p[0] & cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & cin);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
  end

  assign sum  = w_p ^ w_c[3:0];
  assign cout = w_c[4];

endmodule
`default_nettype wire

// File: rtl/cla_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla_nibble_serial_adder
//  Description : WIDTH-bit add/subtract computed one nibble per clock through
//                a single 4-bit lookahead slice, LSB nibble first, with a
//                registered carry between nibbles and valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_nibble_serial_adder
  import cla_nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NIB = WIDTH / C_NIB_W;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] C_LAST = KW'(NIB - 1);

  if (((WIDTH % C_NIB_W) != 0) || (WIDTH < C_NIB_W)) begin : g_width_check
    $fatal(1, "cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;      // already inverted for subtraction
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_sum_nib;
  logic             w_cout_nib;

  // Select the nibble pair for the current step of the operation.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (r_k == KW'(i)) begin
        w_a_nib = r_a[i*C_NIB_W +: C_NIB_W];
        w_b_nib = r_b[i*C_NIB_W +: C_NIB_W];
      end
    end
  end

  carry_lookahead_adder_4_bit u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_sum_nib),
    .cout (w_cout_nib)
  );

  // Handshake FSM plus the nibble datapath it sequences.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= sub ? 1'b1 : cin;
            r_k     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (r_k == KW'(i)) begin
              r_sum[i*C_NIB_W +: C_NIB_W] <= w_sum_nib;
            end
          end
          r_carry <= w_cout_nib;
          if (r_k == C_LAST) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_cout      <= w_cout_nib;
            // Last slice produces the result MSB, so overflow is decided here.
            r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                           (w_sum_nib[3] != r_a[WIDTH-1]);
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // in_ready is the only decoded output; it drops combinationally under reset.
  assign in_ready  = ~rst & (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_nibble_serial_adder
//  Description : Directed vector bench for the nibble-serial CLA adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int n_vec;
  int n_err;

  cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Waits for out_valid; returns number of edges waited, or -1 on timeout.
  task automatic wait_valid(output int edges);
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int edges;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b0;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    a = ~v.a; b = ~v.b; cin = ~v.cin; sub = ~v.sub;  // must not matter now
    wait_valid(edges);
    chk({name, "_latency"}, 32'(edges), 32'(NIB));
    chk({name, "_sum"}, 32'(sum), 32'(v.esum));
    chk({name, "_cout"}, 32'(cout), 32'(v.ecout));
    chk({name, "_ovf"}, 32'(overflow), 32'(v.eovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_release"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    int edges;
    int acc_t[2];
    int n_acc;
    int n_res;
    logic [15:0] b2b_exp[2];

    n_vec = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    //                 a        b        cin   sub   sum      cout  ovf
    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2]  = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[6]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[10] = '{16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    // Reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    tick(); tick();
    chk("rst_outs", 32'({out_valid, cout, overflow}), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: result held while out_ready stays low
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(edges);
    chk("bp_latency", 32'(edges), 32'(NIB));
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid; a = a + 16'h0101; b = ~b; sub = ~sub;
      tick();
      chk("bp_hold_valid", 32'({out_valid, in_ready}), 32'b10);
      chk("bp_hold_sum", 32'({sum, cout, overflow}), 32'({16'h2345, 1'b0, 1'b0}));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", 32'({out_valid, in_ready}), 32'b01);

    // Back-to-back with in_valid held high
    a = 16'h0102; b = 16'h0304; cin = 1'b0; sub = 1'b0;
    b2b_exp[0] = 16'h0406;
    b2b_exp[1] = 16'h0FFE;  // 0x1000 - 0x0002
    in_valid = 1'b1; out_ready = 1'b1;
    n_acc = 0; n_res = 0; acc_t[0] = 0; acc_t[1] = 0;
    for (int cyc = 0; cyc < 30 && n_res < 2; cyc++) begin
      logic acc;
      acc = in_ready & in_valid;
      tick();
      if (acc && n_acc < 2) begin
        acc_t[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          a = 16'h1000; b = 16'h0002; sub = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        chk($sformatf("b2b_sum%0d", n_res), 32'(sum), 32'(b2b_exp[n_res]));
        n_res++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_results", 32'(n_res), 32'd2);
    chk("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'(NIB + 2));
    tick();

    // Reset during RUN aborts the operation
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();           // now in the second RUN cycle
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("abort_outs", 32'({out_valid, cout, overflow}), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready_after", 32'(in_ready), 32'd1);
    run_vec("after_abort", vecs[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
